register_file_mp: RTL and testbench
===================================

# register_file_mp

Parametrised successor to the core register file for the RV32 datapath, with a configurable number of combinational read ports, optional write-to-read bypass, and an integrated pending-write scoreboard. The scoreboard lets the pipelined decode stage detect RAW hazards. It sits between decode (reads, issue marking) and writeback (write, pending clear). Register 0 is hardwired to zero, and reset presets the stack pointer.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREG, 32, number of architectural registers (power of two, ≥ 2)
- AW, $clog2(NREG), register address width (derived)
- NRD, 2, number of read ports (1–4)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
- SP_IDX, 2, index preset to SP_INIT at reset
- SP_INIT, 32'h00008000, reset value of register SP_IDX

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset (reset == 0 at a rising edge resets)
- ra  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
- rd  out  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN]
- rd_busy  out  NRD  port k's register has a pending write not yet satisfied
- we  in  1  write enable
- wa  in  AW  write address
- wd  in  XLEN  write data
- iss_valid  in  1  decode issued an instruction writing iss_rd
- iss_rd  in  AW  destination marked pending
- flush  in  1  clear all pending bits (pipeline squash)

## Operation
- Storage: NREG × XLEN registers and an NREG-bit pending vector.
- Reads are combinational.
  - ra == 0 → rd = 0, rd_busy = 0.
  - Otherwise rd = regs[ra], rd_busy = pending[ra].
- Bypass (BYPASS=1): if we && wa == ra_k && wa != 0, then rd_k = wd and rd_busy_k = 0 in the same cycle.
- BYPASS=0: a read during the writing cycle returns old data and the current pending bit.
- Write: at the edge with we && wa != 0, regs[wa] ← wd. Writes to register 0 are discarded.
- Pending update at each edge, evaluated in this priority order:
  1. flush → all pending cleared. iss_valid is ignored that cycle; we still writes.
  2. Write clears pending[wa] (if we && wa != 0).
  3. Issue sets pending[iss_rd] (if iss_valid && iss_rd != 0). Issue wins over a write clear to the same index, because the newer producer is outstanding.
- Register 0 is never pending.
- Reset (reset == 0 at edge):
  - All regs ← 0 except regs[SP_IDX] ← SP_INIT.
  - All pending ← 0.
  - Reset dominates any concurrent we, iss_valid or flush.
- Reset output values: rd = 0 for every address except SP_IDX (SP_INIT); rd_busy = 0 everywhere.

## Timing
- Read latency: 0 cycles, combinational from ra and register state.
- Write-to-read latency: 1 cycle without bypass, 0 cycles with bypass.
- Issue-to-busy: iss_valid at edge N → rd_busy for that register is 1 from after edge N.
- Write-to-not-busy: we at edge N clears busy after edge N. With BYPASS, busy is already 0 during cycle N.
- Writing the same register twice in consecutive cycles: the last write wins. Any read between the edges sees the first value (or the bypassed second value).
- Reset mid-operation: all state is reset at that edge, with no partial writes. Normal operation resumes on the first edge with reset == 1.
- No handshake back-pressure; every input is sampled on every edge.

## Structure
- Shared package regfile_pkg holds:
  - XLEN and NREG defaults
  - ABI index constants REG_ZERO = 0 and REG_SP = 2
  - SP_INIT_DEFAULT = 32'h00008000
- One sub-module, regfile_scoreboard, owns:
  - the pending vector
  - the flush / clear / set priority logic
  - busy lookup for the NRD ports
- The top level holds storage, read muxing and bypass.

## Test plan
- Reset: hold reset=0 for 2 cycles → read reg 2 = 32'h00008000, regs 1 and 3 = 0, all rd_busy = 0.
- Write/read: we, wa=9, wd=32'h8 → next cycle ra0=9 gives 32'h8. With BYPASS=1, same-cycle ra1=9 also gives 32'h8.
- Register 0: we, wa=0, wd=32'hFFFFFFFF; iss_valid, iss_rd=0 → ra=0 reads 0, rd_busy=0.
- Scoreboard: issue rd=5 → busy=1. The same cycle we, wa=5 and a new issue rd=5 arrive → busy stays 1. A later lone write to 5 → busy=0.
- Flush: issue rd=3, 4, 7 on consecutive cycles, then flush with iss_valid, iss_rd=8 → all busy=0, including 8.
- Reset mid-op: we, wa=2, wd=32'h1234 with reset=0 on the same edge → reg 2 = 32'h00008000.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and ABI register indices for the multi-port register file.
`default_nettype none

package regfile_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 2;

  localparam logic [31:0] SP_INIT_DEFAULT = 32'h0000_8000;

  typedef logic [XLEN_DEFAULT-1:0] word_t;

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write vector with flush/clear/set priority and per-port busy lookup.
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  parameter int AW   = $clog2(NREG),
  parameter int NRD  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] ra_i,
  input  logic              we_i,
  input  logic [AW-1:0]     wa_i,
  input  logic              iss_valid_i,
  input  logic [AW-1:0]     iss_rd_i,
  input  logic              flush_i,
  output logic [NRD-1:0]    busy_o
);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  // Issue is applied after the write clear so a newer producer keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    if (flush_i) begin
      pend_d = '0;
    end else begin
      if (we_i && (wa_i != AW'(REG_ZERO))) begin
        pend_d[wa_i] = 1'b0;
      end
      if (iss_valid_i && (iss_rd_i != AW'(REG_ZERO))) begin
        pend_d[iss_rd_i] = 1'b1;
      end
    end
    pend_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Bit 0 is held clear, so no special case is needed for a read of register 0.
  for (genvar k = 0; k < NRD; k++) begin : g_busy
    assign busy_o[k] = pend_q[ra_i[k*AW +: AW]];
  end

endmodule

`default_nettype wire

// File: rtl/register_file_mp.sv
// register_file_mp: RV32 register file with NRD combinational read ports, optional write bypass
// and an integrated RAW-hazard scoreboard.
`default_nettype none

module register_file_mp
  import regfile_pkg::*;
#(
  parameter int              XLEN    = XLEN_DEFAULT,
  parameter int              NREG    = NREG_DEFAULT,
  parameter int              AW      = $clog2(NREG),
  parameter int              NRD     = 2,
  parameter int              BYPASS  = 1,
  parameter int              SP_IDX  = REG_SP,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NRD-1:0]  sb_busy;
  logic            wr_en;

  assign wr_en = we && (wa != AW'(REG_ZERO));

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else if (wr_en) begin
      regs_q[wa] <= wd;
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW),
    .NRD  (NRD)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .ra_i        (ra),
    .we_i        (we),
    .wa_i        (wa),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .flush_i     (flush),
    .busy_o      (sb_busy)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = ra[k*AW +: AW];

    if (BYPASS != 0) begin : g_bypass
      assign hit = wr_en && (wa == addr);
    end else begin : g_no_bypass
      assign hit = 1'b0;
    end

    assign rd[k*XLEN +: XLEN] = hit ? wd :
                                (addr == AW'(REG_ZERO)) ? '0 : regs_q[addr];
    assign rd_busy[k]         = hit ? 1'b0 : sb_busy[k];
  end

endmodule

`default_nettype wire

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed test-plan sequences plus randomized traffic against an array model.
`default_nettype none

module tb_register_file_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rd_busy;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                flush;

  int errs   = 0;
  int checks = 0;

  logic [XLEN-1:0] m_regs [NREG];
  bit              m_pend [NREG];
  bit              m_valid = 0;

  register_file_mp dut (
    .clk       (clk),
    .reset     (reset),
    .ra        (ra),
    .rd        (rd),
    .rd_busy   (rd_busy),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reads per the spec rules: bypass hit, then register zero, then stored state.
  task automatic check_ports();
    for (int k = 0; k < NRD; k++) begin
      int              a;
      logic [XLEN-1:0] ed;
      logic            eb;
      a = int'(ra[k*AW +: AW]);
      if (we && int'(wa) == a && a != 0) begin
        ed = wd;
        eb = 1'b0;
      end else if (a == 0) begin
        ed = '0;
        eb = 1'b0;
      end else begin
        ed = m_regs[a];
        eb = m_pend[a];
      end
      chk($sformatf("rd%0d[a=%0d]", k, a), rd[k*XLEN +: XLEN], ed);
      chk($sformatf("busy%0d[a=%0d]", k, a), {31'b0, rd_busy[k]}, {31'b0, eb});
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 0;
      end
      m_regs[2] = 32'h0000_8000;
      m_valid   = 1;
    end else begin
      if (we && wa != 0) m_regs[wa] = wd;
      if (flush) begin
        for (int i = 0; i < NREG; i++) m_pend[i] = 0;
      end else begin
        if (we && wa != 0) m_pend[wa] = 0;
        if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1;
      end
    end
  endtask

  task automatic tick();
    #1;
    if (m_valid) check_ports();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b1; we = 1'b0; wa = '0; wd = '0;
    iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  task automatic set_ra(input int a0, input int a1);
    ra = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    idle();
    reset = 1'b0;
    set_ra(0, 0);
    @(negedge clk);
    tick();
    tick();

    // Reset values
    idle();
    set_ra(2, 1);
    #1;
    chk("rst_sp", rd[31:0], 32'h0000_8000);
    chk("rst_r1", rd[63:32], 32'h0);
    chk("rst_busy", {30'b0, rd_busy}, 32'h0);
    set_ra(3, 2);
    #1;
    chk("rst_r3", rd[31:0], 32'h0);
    tick();

    // Write then read, with same-cycle bypass on port 1
    we = 1'b1; wa = 5'd9; wd = 32'h8;
    set_ra(0, 9);
    #1;
    chk("bypass_rd1", rd[63:32], 32'h8);
    tick();
    idle();
    set_ra(9, 0);
    #1;
    chk("wr_rd0", rd[31:0], 32'h8);
    tick();

    // Register 0 stays zero and never pending
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; iss_valid = 1'b1; iss_rd = 5'd0;
    tick();
    idle();
    set_ra(0, 0);
    #1;
    chk("r0_data", rd[31:0], 32'h0);
    chk("r0_busy", {31'b0, rd_busy[0]}, 32'h0);
    tick();

    // Scoreboard: issue beats a same-cycle write clear
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    idle();
    set_ra(5, 0);
    #1;
    chk("sb_issue", {31'b0, rd_busy[0]}, 32'h1);
    we = 1'b1; wa = 5'd5; wd = 32'h55; iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    idle();
    #1;
    chk("sb_reissue", {31'b0, rd_busy[0]}, 32'h1);
    we = 1'b1; wa = 5'd5; wd = 32'h66;
    tick();
    idle();
    #1;
    chk("sb_clear", {31'b0, rd_busy[0]}, 32'h0);
    chk("sb_data", rd[31:0], 32'h66);
    tick();

    // Flush beats a concurrent issue
    for (int r = 0; r < 3; r++) begin
      iss_valid = 1'b1;
      iss_rd = (r == 0) ? 5'd3 : (r == 1) ? 5'd4 : 5'd7;
      tick();
    end
    idle();
    set_ra(3, 7);
    #1;
    chk("pre_flush", {30'b0, rd_busy}, 32'h3);
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd8;
    tick();
    idle();
    for (int r = 3; r <= 8; r++) begin
      set_ra(r, 0);
      #1;
      chk($sformatf("flush_r%0d", r), {31'b0, rd_busy[0]}, 32'h0);
    end
    tick();

    // Reset dominates a concurrent write to SP
    reset = 1'b0; we = 1'b1; wa = 5'd2; wd = 32'h1234;
    set_ra(9, 9);
    tick();
    idle();
    set_ra(2, 9);
    #1;
    chk("midrst_sp", rd[31:0], 32'h0000_8000);
    chk("midrst_r9", rd[63:32], 32'h0);
    tick();

    // Randomized traffic, addresses drawn from a small range to force collisions
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 63) != 0);
      we        = $urandom_range(0, 1);
      wa        = AW'($urandom_range(0, 7));
      wd        = $urandom;
      iss_valid = $urandom_range(0, 1);
      iss_rd    = AW'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 15) == 0);
      set_ra($urandom_range(0, 7), $urandom_range(0, 7));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

`default_nettype wire
